// File: rtl/t03_mem_access_sequencer_if.sv
// Shared single-port memory bus between the access sequencer (master) and memory (slave).
// Requests are held stable until the slave acks or the master aborts.
interface t03_mem_access_sequencer_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_adr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_read, bus_write, bus_adr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_read, bus_write, bus_adr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/t03_mem_access_sequencer.sv
// Sequences instruction fetch and the optional load/store of the team-03 core over a
// single-port bus, freezing the core while a bus transaction is outstanding.
module t03_mem_access_sequencer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] pc,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] data_adr,
    input  logic [31:0] store_data,
    t03_mem_access_sequencer_if.master bus,
    output logic [31:0] instruction,
    output logic [31:0] load_data,
    output logic        freeze,
    output logic        bus_err
);

    localparam int          CW       = $clog2(BUS_TIMEOUT);
    localparam logic [CW-1:0] LAST_CNT = CW'(BUS_TIMEOUT - 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        DATA
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          data_is_write;
    logic          data_is_byte;
    logic [1:0]    data_lane;
    logic [7:0]    rdata_byte;
    logic          timed_out;

    // The word's low two bits never reach the bus; fetches are always word aligned.
    logic unused_pc_bits;
    assign unused_pc_bits = ^pc[1:0];

    always_comb begin
        rdata_byte = bus.bus_rdata[7:0];
        case (data_lane)
            2'd0: rdata_byte = bus.bus_rdata[7:0];
            2'd1: rdata_byte = bus.bus_rdata[15:8];
            2'd2: rdata_byte = bus.bus_rdata[23:16];
            2'd3: rdata_byte = bus.bus_rdata[31:24];
            default: rdata_byte = bus.bus_rdata[7:0];
        endcase
    end

    // An ack on the terminal count cycle still completes normally.
    assign timed_out = !bus.bus_ack && (wait_cnt == LAST_CNT);

    // NOTE: all state here is sequential, so every assignment is non-blocking; each
    // register is a flop updated only from values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            data_is_write <= 1'b0;
            data_is_byte  <= 1'b0;
            data_lane     <= 2'd0;
            instruction   <= '0;
            load_data     <= '0;
            freeze        <= 1'b0;
            bus_err       <= 1'b0;
            bus.bus_read  <= 1'b0;
            bus.bus_write <= 1'b0;
            bus.bus_adr   <= '0;
            bus.bus_sel   <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        state         <= FETCH;
                        wait_cnt      <= '0;
                        freeze        <= 1'b1;
                        bus.bus_read  <= 1'b1;
                        bus.bus_write <= 1'b0;
                        bus.bus_adr   <= {pc[31:2], 2'b00};
                        bus.bus_sel   <= 4'hF;
                        bus.bus_wdata <= '0;
                    end
                end

                FETCH: begin
                    if (bus.bus_ack) begin
                        instruction  <= bus.bus_rdata;
                        state        <= EXEC;
                        bus.bus_read <= 1'b0;
                    end else if (timed_out) begin
                        instruction  <= NOP;
                        state        <= IDLE;
                        freeze       <= 1'b0;
                        bus_err      <= 1'b1;
                        bus.bus_read <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                EXEC: begin
                    if (write_mem || read_mem) begin
                        // A store wins when the decoder flags both.
                        state         <= DATA;
                        wait_cnt      <= '0;
                        data_is_write <= write_mem;
                        data_is_byte  <= load_byte;
                        data_lane     <= data_adr[1:0];
                        bus.bus_read  <= !write_mem;
                        bus.bus_write <= write_mem;
                        bus.bus_adr   <= {data_adr[31:2], 2'b00};
                        if (write_mem ? store_byte : load_byte)
                            bus.bus_sel <= 4'b0001 << data_adr[1:0];
                        else
                            bus.bus_sel <= 4'hF;
                        if (!write_mem)
                            bus.bus_wdata <= '0;
                        else if (store_byte)
                            bus.bus_wdata <= {4{store_data[7:0]}};
                        else
                            bus.bus_wdata <= store_data;
                    end else begin
                        state  <= IDLE;
                        freeze <= 1'b0;
                    end
                end

                DATA: begin
                    if (bus.bus_ack) begin
                        if (!data_is_write)
                            load_data <= data_is_byte ? {24'd0, rdata_byte} : bus.bus_rdata;
                        state         <= IDLE;
                        freeze        <= 1'b0;
                        bus.bus_read  <= 1'b0;
                        bus.bus_write <= 1'b0;
                    end else if (timed_out) begin
                        if (!data_is_write)
                            load_data <= '0;
                        state         <= IDLE;
                        freeze        <= 1'b0;
                        bus_err       <= 1'b1;
                        bus.bus_read  <= 1'b0;
                        bus.bus_write <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    freeze        <= 1'b0;
                    bus.bus_read  <= 1'b0;
                    bus.bus_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t03_mem_access_sequencer.sv
// Randomized transaction-level bench for t03_mem_access_sequencer: the bench plays the
// core and the memory, and predicts each instruction's bus traffic and results.
module tb_t03_mem_access_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] pc;
    logic        read_mem;
    logic        write_mem;
    logic        load_byte;
    logic        store_byte;
    logic [31:0] data_adr;
    logic [31:0] store_data;
    logic [31:0] instruction;
    logic [31:0] load_data;
    logic        freeze;
    logic        bus_err;

    t03_mem_access_sequencer_if bus ();

    t03_mem_access_sequencer #(.BUS_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .read_mem   (read_mem),
        .write_mem  (write_mem),
        .load_byte  (load_byte),
        .store_byte (store_byte),
        .data_adr   (data_adr),
        .store_data (store_data),
        .bus        (bus),
        .instruction(instruction),
        .load_data  (load_data),
        .freeze     (freeze),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_instr;
    logic [31:0] exp_load;
    int          freeze_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expd);
        n_checks++;
        if (got === expd) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, expd);
    endtask

    // One bus phase (fetch or data), entered at the negedge of its first cycle.
    // The memory acks after 'delay' wait cycles; delay >= TO means it never answers.
    task automatic bus_phase(input string tag, input int delay, input logic [31:0] rdata,
                             input logic [31:0] e_adr, input logic [3:0] e_sel,
                             input logic [31:0] e_wdata, input bit e_rd, input bit e_wr,
                             output bit timed_out);
        for (int w = 0; w < TO; w++) begin
            check({tag, "_read"},   bus.bus_read,  e_rd);
            check({tag, "_write"},  bus.bus_write, e_wr);
            check({tag, "_adr"},    bus.bus_adr,   e_adr);
            check({tag, "_sel"},    bus.bus_sel,   e_sel);
            check({tag, "_wdata"},  bus.bus_wdata, e_wdata);
            check({tag, "_freeze"}, freeze,        1);
            freeze_cycles++;
            bus.bus_ack   = (w == delay);
            bus.bus_rdata = (w == delay) ? rdata : $urandom;
            fetch_req     = 1'($urandom_range(0, 1));
            pc            = $urandom;
            data_adr      = $urandom;
            store_data    = $urandom;
            @(negedge clk);
            if (w == delay) begin
                timed_out   = 1'b0;
                bus.bus_ack = 1'b0;
                fetch_req   = 1'b0;
                return;
            end
        end
        timed_out   = 1'b1;
        bus.bus_ack = 1'b0;
        fetch_req   = 1'b0;
    endtask

    // One full instruction, entered and left at a negedge with the sequencer idle.
    task automatic run_instr(input logic [31:0] pc_v, input logic [31:0] instr_v, input int fdelay,
                             input bit rd, input bit wr, input bit lb, input bit sb,
                             input logic [31:0] dadr, input logic [31:0] sdata,
                             input logic [31:0] rdata, input int ddelay);
        bit          to;
        bit          is_wr;
        bit          is_byte;
        int          lane;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        int          e_freeze;

        check("idle_freeze", freeze, 0);
        fetch_req     = 1'b1;
        pc            = pc_v;
        bus.bus_ack   = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        freeze_cycles = 0;
        @(negedge clk);

        bus_phase("fetch", fdelay, instr_v, {pc_v[31:2], 2'b00}, 4'hF, 32'd0, 1'b1, 1'b0, to);
        if (to) begin
            exp_instr = 32'h0000_0013;
            check("fetch_to_err",   bus_err,     1);
            check("fetch_to_instr", instruction, exp_instr);
            check("fetch_to_frz",   freeze,      0);
            check("fetch_to_read",  bus.bus_read, 0);
            check("fetch_to_cycles", freeze_cycles, TO);
            @(negedge clk);
            check("fetch_to_errpulse", bus_err, 0);
            return;
        end
        exp_instr = instr_v;

        check("exec_instr",  instruction,   exp_instr);
        check("exec_freeze", freeze,        1);
        check("exec_req",    {bus.bus_read, bus.bus_write}, 0);
        check("exec_err",    bus_err,       0);
        freeze_cycles++;
        read_mem      = rd;
        write_mem     = wr;
        load_byte     = lb;
        store_byte    = sb;
        data_adr      = dadr;
        store_data    = sdata;
        bus.bus_ack   = 1'($urandom_range(0, 1));
        bus.bus_rdata = $urandom;
        fetch_req     = 1'($urandom_range(0, 1));
        @(negedge clk);
        fetch_req   = 1'b0;
        bus.bus_ack = 1'b0;
        read_mem    = 1'b0;
        write_mem   = 1'b0;
        load_byte   = 1'($urandom_range(0, 1));
        store_byte  = 1'($urandom_range(0, 1));

        if (!rd && !wr) begin
            check("nomem_freeze", freeze,    0);
            check("nomem_req",    {bus.bus_read, bus.bus_write}, 0);
            check("nomem_load",   load_data, exp_load);
            check("nomem_cycles", freeze_cycles, fdelay + 2);
            return;
        end

        is_wr   = wr;
        is_byte = is_wr ? sb : lb;
        lane    = int'(dadr[1:0]);
        e_sel   = is_byte ? 4'(1 << lane) : 4'hF;
        e_wdata = !is_wr ? 32'd0 : (sb ? {4{sdata[7:0]}} : sdata);
        bus_phase("data", ddelay, rdata, {dadr[31:2], 2'b00}, e_sel, e_wdata, !is_wr, is_wr, to);

        if (!is_wr) exp_load = to ? 32'd0 : (lb ? ((rdata >> (8 * lane)) & 32'hFF) : rdata);
        e_freeze = fdelay + 2 + ((ddelay < TO) ? ddelay + 1 : TO);
        check("data_load",   load_data,     exp_load);
        check("data_instr",  instruction,   exp_instr);
        check("data_freeze", freeze,        0);
        check("data_req",    {bus.bus_read, bus.bus_write}, 0);
        check("data_err",    bus_err,       to);
        check("data_cycles", freeze_cycles, e_freeze);
        if (to) begin
            @(negedge clk);
            check("data_errpulse", bus_err, 0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        fetch_req     = 1'b0;
        pc            = '0;
        read_mem      = 1'b0;
        write_mem     = 1'b0;
        load_byte     = 1'b0;
        store_byte    = 1'b0;
        data_adr      = '0;
        store_data    = '0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = '0;
        exp_instr     = '0;
        exp_load      = '0;
        repeat (2) @(negedge clk);
        check("rst_instr",  instruction,   0);
        check("rst_load",   load_data,     0);
        check("rst_adr",    bus.bus_adr,   0);
        check("rst_sel",    bus.bus_sel,   0);
        check("rst_wdata",  bus.bus_wdata, 0);
        check("rst_flags",  {bus.bus_read, bus.bus_write, freeze, bus_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the block's test plan.
        run_instr(32'h100, 32'h0050_0093, 2, 0, 0, 0, 0, 32'h0,    32'h0,        32'h0,        0);
        run_instr(32'h104, 32'h0030_0203, 0, 1, 0, 1, 0, 32'h2003, 32'h0,        32'hAB00_0000, 0);
        run_instr(32'h108, 32'h0020_00A3, 0, 0, 1, 0, 1, 32'h2001, 32'h1234_56C3, 32'h0,       1);
        run_instr(32'h10C, 32'h0020_2023, 1, 1, 1, 0, 0, 32'h3000, 32'hCAFE_F00D, 32'h5555_AAAA, 0);
        run_instr(32'h110, 32'h0000_0000, TO, 0, 0, 0, 0, 32'h0,   32'h0,        32'h0,        0);
        run_instr(32'h114, 32'h00A0_0513, TO - 1, 0, 0, 0, 0, 32'h0, 32'h0,      32'h0,        0);
        run_instr(32'h118, 32'h0000_2283, 0, 1, 0, 0, 0, 32'h4002, 32'h0,        32'h1111_2222, TO + 1);
        run_instr(32'h11C, 32'h0000_2303, 0, 1, 0, 0, 0, 32'h4006, 32'h0,        32'h8765_4321, TO - 1);

        // Randomized instruction stream.
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 3);
            run_instr($urandom, $urandom, $urandom_range(0, TO + 1),
                      op[0], op[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom, $urandom, $urandom, $urandom_range(0, TO + 1));
        end

        // Reset while a data read is outstanding.
        fetch_req = 1'b1;
        pc        = 32'h200;
        @(negedge clk);
        fetch_req     = 1'b0;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h0000_2403;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        read_mem    = 1'b1;
        data_adr    = 32'h5000;
        @(negedge clk);
        read_mem = 1'b0;
        check("mid_rst_read", bus.bus_read, 1);
        rst           = 1'b1;
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.bus_ack = 1'b0;
        check("mid_rst_instr", instruction,   0);
        check("mid_rst_load",  load_data,     0);
        check("mid_rst_adr",   bus.bus_adr,   0);
        check("mid_rst_sel",   bus.bus_sel,   0);
        check("mid_rst_wdata", bus.bus_wdata, 0);
        check("mid_rst_flags", {bus.bus_read, bus.bus_write, freeze, bus_err}, 0);
        rst       = 1'b0;
        exp_instr = 32'd0;
        exp_load  = 32'd0;
        @(negedge clk);
        run_instr(32'h204, 32'h0000_0003, 0, 1, 0, 0, 0, 32'h6000, 32'h0, 32'h0BAD_CAFE, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
